regfile_multiport_sb: RTL and testbench

//  Parametrised multi-port register file for the CPU datapath: N read ports, M write ports, per-register pending scoreboard.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_scoreboard.sv | 48 ++++
 rtl/regfile_multiport_sb.sv | 96 +++++++++
 tb/tb_regfile_multiport_sb.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared sizing constants and helpers for the multi-port register file.
// Port-slice macro: element i of a flat bus of w-bit fields.
`ifndef RF_SLICE
`define RF_SLICE(i, w) (i)*(w) +: (w)
`endif

package rf_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = clog2(RF_DEPTH);
    localparam int REG_ZERO = 1;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-producer bits with issue/writeback/flush priority and a registered busy count.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int DEPTH   = RF_DEPTH,
    parameter  int NWR     = 1,
    parameter  int ZERO_R0 = REG_ZERO,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [DEPTH-1:0]    busy,
    output logic [AW:0]         busy_cnt
);

    logic [DEPTH-1:0] busy_nx;
    logic [AW:0]      cnt_nx;

    // Flush beats issue, issue beats writeback clear (a new producer supersedes the old one).
    always_comb begin
        busy_nx = busy;
        cnt_nx  = '0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[`RF_SLICE(j, AW)] == AW'(r)) busy_nx[r] = 1'b0;
            if (iss_en && iss_addr == AW'(r)) busy_nx[r] = 1'b1;
            if (flush) busy_nx[r] = 1'b0;
        end
        if (ZERO_R0 != 0) busy_nx[0] = 1'b0;
        for (int r = 0; r < DEPTH; r++) cnt_nx = cnt_nx + (AW+1)'(busy_nx[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nx;
            busy_cnt <= cnt_nx;
        end
    end

endmodule

// File: rtl/regfile_multiport_sb.sv
// NRD-read / NWR-write register file with same-cycle write->read bypass and a pending scoreboard.
module regfile_multiport_sb
    import rf_pkg::*;
#(
    parameter  int DW      = RF_DW,
    parameter  int DEPTH   = RF_DEPTH,
    parameter  int NRD     = 2,
    parameter  int NWR     = 1,
    parameter  int ZERO_R0 = REG_ZERO,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*DW-1:0]   rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*DW-1:0]   wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;

    rf_scoreboard #(.DEPTH(DEPTH), .NWR(NWR), .ZERO_R0(ZERO_R0)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        if (ZERO_R0 != 0 && r == 0) begin : g_zero
            assign mem[r] = '0;
        end else begin : g_store
            logic          hit;
            logic [DW-1:0] wd;
            logic [DW-1:0] q;

            // Ascending scan: the highest-index matching port is the one that sticks.
            always_comb begin
                hit = 1'b0;
                wd  = '0;
                for (int j = 0; j < NWR; j++)
                    if (wr_en[j] && wr_addr[`RF_SLICE(j, AW)] == AW'(r)) begin
                        hit = 1'b1;
                        wd  = wr_data[`RF_SLICE(j, DW)];
                    end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   q <= '0;
                else if (hit) q <= wd;
            end

            assign mem[r] = q;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rv;
        logic          byp;
        logic          rb;

        assign ra = rd_addr[`RF_SLICE(i, AW)];

        always_comb begin
            rv  = mem[ra];
            byp = 1'b0;
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[`RF_SLICE(j, AW)] == ra) begin
                    byp = 1'b1;
                    rv  = wr_data[`RF_SLICE(j, DW)];
                end
            rb = busy[ra] & ~byp;
            if (ZERO_R0 != 0 && ra == '0) begin
                rv = '0;
                rb = 1'b0;
            end
        end

        assign rd_data[`RF_SLICE(i, DW)] = rv;
        assign rd_busy[i]                = rb;
    end

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Self-checking bench: table of per-cycle vectors with a queue of expected outputs, plus reset/fill sequences.
module tb_regfile_multiport_sb;

    localparam int DW = 32, DEPTH = 32, NRD = 2, NWR = 2, AW = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en = '0;
    logic [NWR*AW-1:0]   wr_addr = '0;
    logic [NWR*DW-1:0]   wr_data = '0;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_addr = '0;
    logic                flush = 1'b0;
    logic [AW:0]         busy_cnt;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    regfile_multiport_sb #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .ZERO_R0(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [31:0] e_d0, e_d1;
        logic [1:0]  e_b;
        logic [5:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] d0, d1;
        logic [1:0]  b;
        logic [5:0]  cnt;
    } exp_t;

    vec_t vecs[16];
    exp_t expq[$];

    function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                                logic [4:0] wa1, logic [31:0] wd1, logic [4:0] ra0, logic [4:0] ra1,
                                logic ie, logic [4:0] ia, logic fl,
                                logic [31:0] e_d0, logic [31:0] e_d1, logic [1:0] e_b, logic [5:0] e_cnt);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.ie = ie; v.ia = ia; v.fl = fl;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_b = e_b; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; iss_en = 1'b0; flush = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (expq.size() == 0) begin
            chk({tag, " queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = expq.pop_front();
        chk({tag, " rd_data0"}, rd_data[31:0],  e.d0);
        chk({tag, " rd_data1"}, rd_data[63:32], e.d1);
        chk({tag, " rd_busy"},  32'(rd_busy),   32'(e.b));
        chk({tag, " busy_cnt"}, 32'(busy_cnt),  32'(e.cnt));
    endtask

    initial begin
        // d0/d1 = read data, b = {busy1,busy0}, cnt = busy_cnt before this cycle's edge
        vecs[0]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0,        5,  6, 0, 0,  0, 32'hDEADBEEF, 0,            2'b00, 0);
        vecs[1]  = mk(2'b00, 0, 0,            0, 0,        5,  5, 0, 0,  0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        vecs[2]  = mk(2'b11, 7, 32'h11,       7, 32'h22,   7,  5, 0, 0,  0, 32'h22,       32'hDEADBEEF, 2'b00, 0);
        vecs[3]  = mk(2'b00, 0, 0,            0, 0,        7,  0, 0, 0,  0, 32'h22,       0,            2'b00, 0);
        vecs[4]  = mk(2'b01, 0, 32'hFFFFFFFF, 0, 0,        0,  7, 0, 0,  0, 0,            32'h22,       2'b00, 0);
        vecs[5]  = mk(2'b00, 0, 0,            0, 0,        0,  3, 1, 3,  0, 0,            0,            2'b00, 0);
        vecs[6]  = mk(2'b00, 0, 0,            0, 0,        3,  5, 0, 0,  0, 0,            32'hDEADBEEF, 2'b01, 1);
        vecs[7]  = mk(2'b01, 3, 32'h33,       0, 0,        3,  3, 0, 0,  0, 32'h33,       32'h33,       2'b00, 1);
        vecs[8]  = mk(2'b00, 0, 0,            0, 0,        3,  9, 0, 0,  0, 32'h33,       0,            2'b00, 0);
        vecs[9]  = mk(2'b01, 9, 32'h99,       0, 0,        9,  3, 1, 9,  0, 32'h99,       32'h33,       2'b00, 0);
        vecs[10] = mk(2'b00, 0, 0,            0, 0,        9,  4, 1, 4,  1, 32'h99,       0,            2'b01, 1);
        vecs[11] = mk(2'b00, 0, 0,            0, 0,        9,  4, 0, 0,  0, 32'h99,       0,            2'b00, 0);
        vecs[12] = mk(2'b00, 0, 0,            0, 0,        0, 12, 1, 0,  0, 0,            0,            2'b00, 0);
        vecs[13] = mk(2'b10, 0, 0,           12, 32'hA5A5A5A5, 0, 12, 1, 20, 0, 0,        32'hA5A5A5A5, 2'b00, 0);
        vecs[14] = mk(2'b00, 5'bx, 32'bx,    5'bx, 32'bx, 20, 12, 0, 5'bx, 0, 0,          32'hA5A5A5A5, 2'b01, 1);
        vecs[15] = mk(2'b00, 0, 0,            0, 0,        5, 12, 0, 0,  0, 32'hDEADBEEF, 32'hA5A5A5A5, 2'b00, 1);

        // Reset state: sweep every address on both ports
        #2;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("reset rd0[%0d]", i), rd_data[31:0], 0);
            chk($sformatf("reset rd1[%0d]", 31 - i), rd_data[63:32], 0);
            chk($sformatf("reset busy[%0d]", i), 32'(rd_busy), 0);
        end
        chk("reset busy_cnt", 32'(busy_cnt), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 16; k++) begin
            exp_t e;
            wr_en = vecs[k].we;
            wr_addr = {vecs[k].wa1, vecs[k].wa0};
            wr_data = {vecs[k].wd1, vecs[k].wd0};
            rd_addr = {vecs[k].ra1, vecs[k].ra0};
            iss_en = vecs[k].ie; iss_addr = vecs[k].ia; flush = vecs[k].fl;
            e.d0 = vecs[k].e_d0; e.d1 = vecs[k].e_d1; e.b = vecs[k].e_b; e.cnt = vecs[k].e_cnt;
            expq.push_back(e);
            #3;
            pop_check($sformatf("vec%0d", k));
            @(posedge clk); #1;
        end
        idle();

        // Fill: issue every address, r0 stays free so count tops out at DEPTH-1
        for (int i = 0; i < DEPTH; i++) begin
            iss_en = 1'b1; iss_addr = 5'(i);
            @(posedge clk); #1;
        end
        idle();
        chk("fill busy_cnt", 32'(busy_cnt), 31);
        flush = 1'b1;
        @(posedge clk); #1;
        idle();
        chk("flush busy_cnt", 32'(busy_cnt), 0);

        // Mid-cycle async reset clears contents and busy at once
        iss_en = 1'b1; iss_addr = 5'd20;
        @(posedge clk); #1;
        idle();
        rd_addr = {5'd20, 5'd12};
        #1;
        chk("pre-rst rd12", rd_data[31:0], 32'hA5A5A5A5);
        chk("pre-rst busy20", 32'(rd_busy[1]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-rst rd12", rd_data[31:0], 0);
        chk("mid-rst busy20", 32'(rd_busy[1]), 0);
        chk("mid-rst busy_cnt", 32'(busy_cnt), 0);
        // A write presented while in reset must be lost
        wr_en = 2'b01; wr_addr = {5'd0, 5'd13}; wr_data = {32'd0, 32'h77};
        @(posedge clk); #1;
        idle();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        rd_addr = {5'd7, 5'd13};
        #1;
        chk("post-rst rd13", rd_data[31:0], 0);
        chk("post-rst rd7", rd_data[63:32], 0);
        chk("post-rst busy_cnt", 32'(busy_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
